// File: rtl/dmem_controller.sv
// Data-memory controller: turns byte/half/word loads and stores into word-wide
// accesses on a backing port without byte enables (sub-word stores use read-modify-write).
module dmem_controller #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dreq_valid,
    output logic              dreq_ready,
    input  logic              dreq_wen,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [XLEN-1:0]   dreq_wdata,
    input  logic [1:0]        dreq_wmask,
    output logic              dresp_valid,
    output logic [XLEN-1:0]   dresp_rdata,
    output logic              dresp_err,
    output logic              store_fault,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_rdata
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;

    typedef struct packed {
        logic              wen;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   wdata;
    } req_t;

    state_t          state, state_nx;
    req_t            req_q;
    logic [XLEN-1:0] wbuf_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;
    logic            fault_q;
    logic            ready_q;

    logic            accept;
    logic            aligned_in;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] lane_mask;
    logic [XLEN-1:0] load_word;
    logic [XLEN-1:0] merged;

    assign accept = dreq_valid && ready_q;

    always_comb begin
        case (dreq_wmask)
            2'd0:    aligned_in = 1'b1;
            2'd1:    aligned_in = ~dreq_addr[0];
            default: aligned_in = (dreq_addr[1:0] == 2'b00);
        endcase
    end

    // Byte offset scaled to bits; size 3 behaves as a full word.
    assign shamt = SHW'({req_q.addr[1:0], 3'b000});

    always_comb begin
        case (req_q.size)
            2'd0:    lane_mask = XLEN'(8'hFF);
            2'd1:    lane_mask = XLEN'(16'hFFFF);
            default: lane_mask = '1;
        endcase
    end

    assign load_word = (mem_resp_rdata >> shamt) & lane_mask;
    assign merged    = (mem_resp_rdata & ~(lane_mask << shamt))
                     | ((req_q.wdata & lane_mask) << shamt);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!aligned_in)
                        state_nx = dreq_wen ? IDLE : RESP;
                    else if (dreq_wen && dreq_wmask[1])
                        state_nx = WR_REQ;
                    else
                        state_nx = RD_REQ;
                end
            end
            RD_REQ:  if (mem_req_ready) state_nx = RD_WAIT;
            RD_WAIT: if (mem_resp_valid) state_nx = req_q.wen ? WR_REQ : RESP;
            WR_REQ:  if (mem_req_ready) state_nx = IDLE;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            req_q   <= '0;
            wbuf_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            fault_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx == IDLE);
            fault_q <= accept && dreq_wen && !aligned_in;
            if (accept) begin
                req_q <= '{wen: dreq_wen, size: dreq_wmask, addr: dreq_addr, wdata: dreq_wdata};
                if (dreq_wen && dreq_wmask[1])
                    wbuf_q <= dreq_wdata;
                if (!dreq_wen && !aligned_in) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
            if (state == RD_WAIT && mem_resp_valid) begin
                if (req_q.wen) begin
                    wbuf_q <= merged;
                end else begin
                    rdata_q <= load_word;
                    err_q   <= 1'b0;
                end
            end
        end
    end

    assign dreq_ready    = ready_q;
    assign dresp_valid   = (state == RESP);
    assign dresp_rdata   = rdata_q;
    assign dresp_err     = err_q;
    assign store_fault   = fault_q;
    assign mem_req_valid = (state == RD_REQ) || (state == WR_REQ);
    assign mem_req_wen   = (state == WR_REQ);
    assign mem_req_addr  = {req_q.addr[ADDR_W-1:2], 2'b00};
    assign mem_req_wdata = wbuf_q;

endmodule

// File: tb/tb_dmem_controller.sv
// Scoreboard bench for dmem_controller: behavioural backing memory with
// programmable request stall and response delay, decoupled response monitor.
module tb_dmem_controller;
    localparam int XLEN = 32, ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              dreq_valid = 1'b0;
    logic              dreq_ready;
    logic              dreq_wen = 1'b0;
    logic [ADDR_W-1:0] dreq_addr = '0;
    logic [XLEN-1:0]   dreq_wdata = '0;
    logic [1:0]        dreq_wmask = 2'd0;
    logic              dresp_valid;
    logic [XLEN-1:0]   dresp_rdata;
    logic              dresp_err;
    logic              store_fault;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b1;
    logic              mem_req_wen;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [XLEN-1:0]   mem_req_wdata;
    logic              mem_resp_valid = 1'b0;
    logic [XLEN-1:0]   mem_resp_rdata = '0;

    dmem_controller #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_wen(dreq_wen),
        .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata), .dreq_wmask(dreq_wmask),
        .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata), .dresp_err(dresp_err),
        .store_fault(store_fault),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] rdata; logic err; } resp_t;
    resp_t       exp_resp[$];
    logic [63:0] exp_wr[$];
    int          exp_fault = 0;

    logic [31:0] mem [logic [31:0]];
    int          stall_cnt = 0, resp_extra = 0, n_rd = 0, n_wr = 0, n_resp = 0, resp_cyc = 0;
    logic        rd_pend = 1'b0;
    int          rd_cnt = 0;
    logic [31:0] rd_data = '0;
    logic        prev_stall = 1'b0;
    logic [64:0] prev_req = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Backing memory: decides ready and detects the handshake half a cycle
    // before the edge that completes it; read data returns resp_extra cycles late.
    always @(negedge clk) begin
        logic [63:0] e;
        mem_resp_valid = 1'b0;
        if (prev_stall) begin
            chk("req_hold_valid", {63'd0, mem_req_valid}, 64'd1);
            chk("req_hold_fields", {mem_req_wen, mem_req_addr, mem_req_wdata}, prev_req);
        end
        if (rd_pend) begin
            if (rd_cnt == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = rd_data;
                rd_pend = 1'b0;
            end else rd_cnt--;
        end
        mem_req_ready = 1'b1;
        if (mem_req_valid && stall_cnt > 0) begin
            mem_req_ready = 1'b0;
            stall_cnt--;
        end
        prev_stall = mem_req_valid && !mem_req_ready;
        prev_req   = {mem_req_wen, mem_req_addr, mem_req_wdata};
        if (mem_req_valid && mem_req_ready && !reset) begin
            if (mem_req_wen) begin
                n_wr++;
                if (exp_wr.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: addr %0h data %0h", mem_req_addr, mem_req_wdata);
                end else begin
                    e = exp_wr.pop_front();
                    chk("write_addr_data", {mem_req_addr, mem_req_wdata}, e);
                end
                mem[mem_req_addr] = mem_req_wdata;
            end else begin
                n_rd++;
                rd_pend = 1'b1;
                rd_cnt  = resp_extra;
                rd_data = mem.exists(mem_req_addr) ? mem[mem_req_addr] : 32'h0;
            end
        end
    end

    // Response / fault monitor
    always @(negedge clk) begin
        resp_t e;
        if (dresp_valid) begin
            n_resp++;
            resp_cyc = cyc;
            if (exp_resp.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_dresp: rdata %0h err %0b", dresp_rdata, dresp_err);
            end else begin
                e = exp_resp.pop_front();
                chk("dresp_rdata", {32'd0, dresp_rdata}, {32'd0, e.rdata});
                chk("dresp_err", {63'd0, dresp_err}, {63'd0, e.err});
            end
        end
        if (store_fault) begin
            tests++;
            if (exp_fault == 0) begin
                fails++;
                $display("FAIL unexpected_store_fault: got 1 expected 0");
            end else exp_fault--;
        end
    end

    task automatic req(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, output int acc);
        int n = 0;
        while (!dreq_ready && n < 100) begin @(negedge clk); n++; end
        if (!dreq_ready) begin
            tests++; fails++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
        dreq_valid = 1'b1; dreq_wen = wen; dreq_addr = addr; dreq_wdata = wd; dreq_wmask = sz;
        @(posedge clk);
        @(negedge clk);
        // scramble inputs: only the latched copy may matter now
        dreq_valid = 1'b0; dreq_wen = ~wen; dreq_addr = 32'hFFFF_FFFF;
        dreq_wdata = 32'h5A5A_5A5A; dreq_wmask = ~sz;
        acc = cyc;
    endtask

    // Returns the T-index (accept = T0) of the first cycle dreq_ready is high.
    task automatic wait_ready(input int acc, output int t);
        int n = 0;
        while (!dreq_ready && n < 200) begin @(negedge clk); n++; end
        if (!dreq_ready) begin
            tests++; fails++;
            $display("FAIL done_timeout: got 0 expected 1");
        end
        t = cyc - acc + 1;
    endtask

    initial begin
        int acc, t, r0, rd0, wr0;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, t, r0, rd0, wr0;
        mem[32'h100] = 32'hDEADBEEF;
        mem[32'h200] = 32'h11223344;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_ready", {63'd0, dreq_ready}, 64'd1);
        chk("reset_outs", {dresp_valid, dresp_err, store_fault, mem_req_valid, mem_req_wen},
            64'd0);
        chk("reset_data", {dresp_rdata, mem_req_addr}, 64'd0);

        // loads from 0xDEADBEEF
        exp_resp.push_back('{32'h000000AD, 1'b0});
        req(1'b0, 32'h102, 32'h0, 2'd0, acc);
        wait_ready(acc, t);
        chk("ldB_ready_T", t, 4);
        chk("ldB_resp_T", resp_cyc - acc + 1, 3);
        exp_resp.push_back('{32'h0000DEAD, 1'b0});
        req(1'b0, 32'h102, 32'h0, 2'd1, acc);
        wait_ready(acc, t);
        chk("ldH_ready_T", t, 4);
        exp_resp.push_back('{32'hDEADBEEF, 1'b0});
        req(1'b0, 32'h100, 32'h0, 2'd2, acc);
        wait_ready(acc, t);
        chk("ldW_resp_T", resp_cyc - acc + 1, 3);

        // sub-word stores: read-modify-write
        rd0 = n_rd; wr0 = n_wr; r0 = n_resp;
        exp_wr.push_back({32'h200, 32'h1122AA44});
        req(1'b1, 32'h201, 32'hFFFF_FFAA, 2'd0, acc);
        wait_ready(acc, t);
        @(negedge clk);
        chk("stB_ready_T", t, 4);
        chk("stB_rw_count", {n_rd - rd0, n_wr - wr0}, {32'd1, 32'd1});
        chk("stB_no_resp", n_resp - r0, 0);
        chk("stB_mem", mem[32'h200], 32'h1122AA44);

        mem[32'h200] = 32'h11223344;
        exp_wr.push_back({32'h200, 32'hBEEF3344});
        req(1'b1, 32'h202, 32'h1234BEEF, 2'd1, acc);
        wait_ready(acc, t);
        @(negedge clk);
        chk("stH_mem", mem[32'h200], 32'hBEEF3344);

        // word store: no read
        rd0 = n_rd; wr0 = n_wr;
        exp_wr.push_back({32'h204, 32'h5});
        req(1'b1, 32'h204, 32'h5, 2'd2, acc);
        wait_ready(acc, t);
        @(negedge clk);
        chk("stW_ready_T", t, 2);
        chk("stW_rw_count", {n_rd - rd0, n_wr - wr0}, {32'd0, 32'd1});

        // misaligned load
        rd0 = n_rd; wr0 = n_wr;
        exp_resp.push_back('{32'h0, 1'b1});
        req(1'b0, 32'h101, 32'h0, 2'd1, acc);
        wait_ready(acc, t);
        chk("misld_ready_T", t, 2);
        repeat (3) @(negedge clk);
        chk("misld_hold", {dresp_err, dresp_rdata}, {1'b1, 32'h0});
        chk("misld_no_mem", {n_rd - rd0, n_wr - wr0}, 64'd0);

        // misaligned store
        exp_fault = 1;
        req(1'b1, 32'h206, 32'h77, 2'd2, acc);
        wait_ready(acc, t);
        @(negedge clk);
        chk("misst_ready_T", t, 1);
        chk("misst_fault_seen", exp_fault, 0);
        chk("misst_no_mem", {n_rd - rd0, n_wr - wr0}, 64'd0);
        chk("misst_mem", mem[32'h204], 32'h5);

        // stalled request and late response
        mem[32'h300] = 32'hCAFEF00D;
        stall_cnt = 3; resp_extra = 4; r0 = n_resp;
        exp_resp.push_back('{32'hCAFEF00D, 1'b0});
        req(1'b0, 32'h300, 32'h0, 2'd3, acc);
        wait_ready(acc, t);
        @(negedge clk);
        chk("stall_ready_T", t, 11);
        chk("stall_resp_once", n_resp - r0, 1);
        stall_cnt = 2;
        exp_wr.push_back({32'h300, 32'h55FEF00D});
        req(1'b1, 32'h303, 32'h0000_0055, 2'd0, acc);
        wait_ready(acc, t);
        @(negedge clk);
        chk("stall_stB_mem", mem[32'h300], 32'h55FEF00D);

        // reset while waiting for read data; the late response must be ignored
        r0 = n_resp;
        req(1'b0, 32'h100, 32'h0, 2'd2, acc);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_ready", {63'd0, dreq_ready}, 64'd1);
        repeat (8) @(negedge clk);
        chk("rst_mid_no_resp", n_resp - r0, 0);
        chk("rst_mid_idle", {63'd0, mem_req_valid}, 64'd0);
        resp_extra = 0;
        exp_resp.push_back('{32'h000000EF, 1'b0});
        req(1'b0, 32'h100, 32'h0, 2'd0, acc);
        wait_ready(acc, t);
        @(negedge clk);
        chk("post_rst_ready_T", t, 4);

        repeat (3) @(negedge clk);
        chk("sb_resp_empty", exp_resp.size(), 0);
        chk("sb_wr_empty", exp_wr.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_controller.md
Name: dmem_controller

Overview:
- Data-memory controller directly downstream of the memory stage: consumes its DReq (valid/ready/wen/addr/wdata/wmask) and produces DResp (valid/rdata).
- Converts byte/half/word accesses into word-wide accesses on a backing memory port that has no byte enables.
- Sub-word stores are performed as read-modify-write. Load data is returned right-aligned and not sign-extended; the stage extends it.

Parameters:
XLEN, 32, data width; word = XLEN/8 bytes, byte offset = addr[1:0]
ADDR_W, 32, address width

Ports:
clk  in  1  clock
reset  in  1  reset
dreq_valid  in  1  request valid from memory stage
dreq_ready  out  1  controller can accept a request
dreq_wen  in  1  1=store, 0=load
dreq_addr  in  ADDR_W  byte address
dreq_wdata  in  XLEN  store data, right-aligned
dreq_wmask  in  2  access size: 0=B, 1=H, 2=W, 3=reserved (treated as W)
dresp_valid  out  1  load data valid, one-cycle pulse
dresp_rdata  out  XLEN  load data, right-aligned, upper bits zero
dresp_err  out  1  qualifies dresp_valid: misaligned load
store_fault  out  1  one-cycle pulse: misaligned store dropped
mem_req_valid  out  1  backing memory request valid
mem_req_ready  in  1  backing memory accepts request
mem_req_wen  out  1  backing write
mem_req_addr  out  ADDR_W  word-aligned address (addr[1:0]=0)
mem_req_wdata  out  XLEN  full-word write data
mem_resp_valid  in  1  backing read data valid
mem_resp_rdata  in  XLEN  backing read word

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0 except dreq_ready=1.
- Reset mid-operation abandons the transaction. An already-issued backing read may still return; mem_resp_valid in IDLE is ignored.
- Request acceptance: dreq_ready = (state==IDLE), driven from a register. A request is accepted on dreq_valid && dreq_ready. All fields are latched and only the latched copies are used afterwards.
- Store completion is the accept handshake; stores never produce dresp_valid. The write still proceeds internally, and dreq_ready stays low until it is done.
- Loads: dresp_valid pulses exactly once. There is no backpressure on dresp.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=0.
  - Misaligned load: no memory access. Go to RESP; dresp_valid=1, dresp_err=1, dresp_rdata=0 on the cycle after accept.
  - Misaligned store: no memory access. store_fault=1 on the cycle after accept. Return to IDLE (dreq_ready=1) that same cycle.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
  - IDLE -> RD_REQ: aligned load or aligned sub-word store.
  - IDLE -> WR_REQ: aligned word store.
  - RD_REQ: mem_req_valid=1, wen=0, addr={addr[ADDR_W-1:2],2'b00}. Held stable until mem_req_ready, then -> RD_WAIT.
  - RD_WAIT: on mem_resp_valid:
    - load: capture word>>(8*addr[1:0]), masked to size (B: [7:0], H: [15:0]) -> RESP.
    - sub-word store: merged word = read word with the target byte/half replaced by wdata[7:0]/[15:0] at the offset -> WR_REQ.
  - WR_REQ: mem_req_valid=1, wen=1, wdata=merged or full word. Held stable until mem_req_ready -> IDLE.
  - RESP: dresp_valid=1 for one cycle -> IDLE.
- mem_req_valid must not drop before mem_req_ready.
- mem_resp_valid is accepted no earlier than the cycle after the read handshake.
- Latency with mem_req_ready=1 and a 1-cycle memory:
  - load accept at T0: req at T1, resp at T2, dresp_valid at T3, dreq_ready at T4.
  - word store: write at T1, dreq_ready at T2.
  - sub-word store: read T1, resp T2, write T3, dreq_ready T4.
- dresp_rdata and dresp_err hold their value until the next response. dresp_err=0 for good loads.
- Back-to-back: the earliest next accept is the cycle dreq_ready returns high. No overlap between transactions.

Test Plan:
- Word at 0x100 = 0xDEADBEEF; load B at 0x102 -> dresp_rdata=0x000000AD, err=0; load H at 0x102 -> 0x0000DEAD; load W -> 0xDEADBEEF; latency T3 with ideal memory.
- Word at 0x200 = 0x11223344; store B wdata=0xAA at 0x201 -> single read then write 0x1122AA44 to 0x200; dreq_ready low T1..T3, high T4; no dresp_valid.
- Store H 0xBEEF at 0x202 over 0x11223344 -> 0xBEEF3344. Store W 0x5 at 0x204 -> one write, no read, ready at T2.
- Load H at 0x101 -> dresp_valid with err=1, rdata=0, no mem_req_valid. Store W at 0x206 -> store_fault pulse, memory unchanged.
- mem_req_ready low 3 cycles and mem_resp_valid 4 cycles late -> mem_req_valid/addr stable throughout, correct data, dresp_valid exactly once, dreq_ready low until done.
- Assert reset in RD_WAIT, then return a late mem_resp_valid -> ignored; dreq_ready=1 after reset; next load completes correctly.
